// File: rtl/instr_fetch_window.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_window
// Purpose  : Buffers the trace byte stream and presents a left-aligned
//            12-byte window to decode. Optional retirement statistics are
//            enabled by defining INSTR_FETCH_WINDOW_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_window #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        win_valid,
    output logic [95:0] raw_instr,
    output logic [4:0]  win_count,
    input  logic        consume,
    input  logic [3:0]  consume_len,
    output logic        done,
`ifdef INSTR_FETCH_WINDOW_STATS_EN
    output logic [31:0] instr_retired,
    output logic [31:0] bytes_retired,
`endif
    output logic        err
);

    localparam int BW = DEPTH * 8;

    generate
        if (DEPTH < 12 || DEPTH > 31) begin : g_depth_check
            $error("instr_fetch_window: DEPTH must be in 12..31");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_READY = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [BW-1:0]   r_buf;
    logic [BW-1:0]   w_buf_next;
    logic [4:0]      r_count;
    logic [4:0]      w_count_next;
    logic            r_eos;
    logic            w_eos_next;
    logic            r_rst_q;
    logic [4:0]      w_avail;
    logic [4:0]      w_clen;
    logic [4:0]      w_pos;
    logic            w_violation;
    logic            w_freeze;
    logic            w_push;
    logic            w_pop;

    // Byte 0 sits in the MSBs; positions at or beyond r_count are always zero,
    // so the window is just the top 96 bits.
    assign raw_instr = r_buf[BW-1 -: 96];
    assign win_count = r_count;
    assign win_valid = (r_state == S_READY) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);
    assign in_ready  = !r_rst_q && (r_count < 5'(DEPTH)) && !r_eos && (r_state != S_ERR);

    always_comb begin
        w_avail      = (r_count >= 5'd12) ? 5'd12 : r_count;
        w_violation  = 1'b0;
        if (consume && (!win_valid || consume_len == 4'd0 || {1'b0, consume_len} > w_avail))
            w_violation = 1'b1;
        if (in_valid && in_last && r_eos)
            w_violation = 1'b1;
        w_freeze     = w_violation || (r_state == S_ERR);
        w_push       = in_valid && in_ready && !w_freeze;
        w_pop        = consume && !w_freeze;
        w_clen       = w_pop ? {1'b0, consume_len} : 5'd0;
        w_pos        = r_count - w_clen;
        w_count_next = r_count - w_clen + {4'd0, w_push};
        w_eos_next   = r_eos || (w_push && in_last);
        // Retire first, then drop the new byte right behind the survivors.
        w_buf_next   = (r_buf << {w_clen, 3'b000})
                     | (w_push ? ({in_data, {(BW-8){1'b0}}} >> {w_pos, 3'b000}) : '0);

        w_state_next = S_FILL;
        if (w_freeze)
            w_state_next = S_ERR;
        else if (w_count_next >= 5'd12)
            w_state_next = S_READY;
        else if (w_eos_next)
            w_state_next = (w_count_next == 5'd0) ? S_DONE : S_DRAIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_count <= 5'd0;
            r_eos   <= 1'b0;
            r_rst_q <= 1'b1;
        end else begin
            r_buf   <= w_buf_next;
            r_count <= w_count_next;
            r_eos   <= w_eos_next;
            r_rst_q <= 1'b0;
        end
    end

`ifdef INSTR_FETCH_WINDOW_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_retired <= 32'd0;
            bytes_retired <= 32'd0;
        end else if (w_pop) begin
            instr_retired <= instr_retired + 32'd1;
            bytes_retired <= bytes_retired + {28'd0, consume_len};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_window
// Purpose  : Directed and randomized bench for instr_fetch_window against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_window;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        win_valid;
    logic [95:0] raw_instr;
    logic [4:0]  win_count;
    logic        consume = 1'b0;
    logic [3:0]  consume_len = 4'd0;
    logic        done;
    logic        err;
`ifdef INSTR_FETCH_WINDOW_STATS_EN
    logic [31:0] instr_retired;
    logic [31:0] bytes_retired;
`endif

    instr_fetch_window #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .win_valid   (win_valid),
        .raw_instr   (raw_instr),
        .win_count   (win_count),
        .consume     (consume),
        .consume_len (consume_len),
        .done        (done),
`ifdef INSTR_FETCH_WINDOW_STATS_EN
        .instr_retired (instr_retired),
        .bytes_retired (bytes_retired),
`endif
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Reference model: byte queue plus end-of-stream / error / post-reset flags.
    logic [7:0]  q[$];
    bit          m_eos, m_err, m_post;
    int unsigned m_ir, m_br;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_avail();
        return (q.size() >= 12) ? 12 : q.size();
    endfunction

    function automatic bit m_win_valid();
        return !m_err && (q.size() >= 12 || (m_eos && q.size() > 0));
    endfunction

    function automatic bit m_in_ready();
        return !m_post && q.size() < DEPTH && !m_eos && !m_err;
    endfunction

    function automatic logic [95:0] m_raw();
        logic [95:0] w = '0;
        for (int i = 0; i < 12; i++)
            if (i < q.size()) w[95-8*i -: 8] = q[i];
        return w;
    endfunction

    task automatic compare_all();
        check("in_ready",  96'(in_ready),  96'(m_in_ready()));
        check("win_valid", 96'(win_valid), 96'(m_win_valid()));
        check("raw_instr", raw_instr,      m_raw());
        check("win_count", 96'(win_count), 96'(q.size()));
        check("done",      96'(done),      96'(!m_err && m_eos && q.size() == 0));
        check("err",       96'(err),       96'(m_err));
`ifdef INSTR_FETCH_WINDOW_STATS_EN
        check("instr_retired", 96'(instr_retired), 96'(m_ir));
        check("bytes_retired", 96'(bytes_retired), 96'(m_br));
`endif
    endtask

    task automatic step(input bit r, input bit iv, input logic [7:0] d, input bit il,
                        input bit c, input logic [3:0] cl);
        bit viol, rdy;
        if (cmp_en) compare_all();
        rst = r; in_valid = iv; in_data = d; in_last = il; consume = c; consume_len = cl;
        if (r) begin
            q.delete(); m_eos = 0; m_err = 0; m_post = 1; m_ir = 0; m_br = 0;
        end else begin
            viol = (c && (!m_win_valid() || cl == 0 || int'(cl) > m_avail())) || (iv && il && m_eos);
            rdy  = m_in_ready();
            if (m_err || viol) begin
                m_err = 1;
            end else begin
                if (c) begin
                    repeat (int'(cl)) void'(q.pop_front());
                    m_ir++;
                    m_br += int'(cl);
                end
                if (iv && rdy) begin
                    q.push_back(d);
                    if (il) m_eos = 1;
                end
            end
            m_post = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit il);
        step(0, 1, d, il, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;

        // Fill to one window
        check("post_rst_ready", 96'(in_ready), 96'(0));
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) push(8'(i), 0);
        check("t1_wv_11", 96'(win_valid), 96'(0));
        push(8'h0B, 0);
        check("t1_wv",    96'(win_valid), 96'(1));
        check("t1_raw",   raw_instr, 96'h000102030405060708090A0B);
        check("t1_count", 96'(win_count), 96'(12));

        // Fill to capacity, extra byte held
        for (int i = 12; i < 16; i++) push(8'(i), 0);
        check("t2_ready", 96'(in_ready), 96'(0));
        push(8'h10, 0);
        check("t2_count", 96'(win_count), 96'(16));

        // Consume while the extra byte is held
        step(0, 1, 8'h10, 0, 1, 4'd3);
        check("t3_raw",   raw_instr, 96'h030405060708090A0B0C0D0E);
        check("t3_count", 96'(win_count), 96'(13));
        push(8'h10, 0);
        check("t3_count2", 96'(win_count), 96'(14));
        step(0, 0, 0, 0, 1, 4'd12);
        check("t3_pos13", raw_instr, 96'h0F10 << 80);

        // Short trace drains to done
        do_reset();
        push(8'h90, 0);
        push(8'hC3, 1);
        check("t4_wv",    96'(win_valid), 96'(1));
        check("t4_raw",   raw_instr, 96'h90C3 << 80);
        check("t4_count", 96'(win_count), 96'(2));
        step(0, 0, 0, 0, 1, 4'd1);
        check("t4_raw2",  raw_instr, 96'hC3 << 88);
        step(0, 0, 0, 0, 1, 4'd1);
        check("t4_done",  96'(done), 96'(1));
        check("t4_wv0",   96'(win_valid), 96'(0));
        check("t4_rdy0",  96'(in_ready), 96'(0));

        // Over-consume in drain, then recover by reset
        do_reset();
        push(8'h90, 0);
        push(8'hC3, 1);
        step(0, 0, 0, 0, 1, 4'd3);
        check("t5_err", 96'(err), 96'(1));
        check("t5_wv",  96'(win_valid), 96'(0));
        step(1, 0, 0, 0, 0, 0);
        check("t5_err0",   96'(err), 96'(0));
        check("t5_count0", 96'(win_count), 96'(0));
        check("t5_done0",  96'(done), 96'(0));

`ifdef INSTR_FETCH_WINDOW_STATS_EN
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) push(8'(i + 32), 0);
        step(0, 0, 0, 0, 1, 4'd1);
        step(0, 1, 8'h55, 0, 1, 4'd5);
        push(8'h56, 0);
        step(0, 0, 0, 0, 1, 4'd12);
        check("t6_ir", 96'(instr_retired), 96'(3));
        check("t6_br", 96'(bytes_retired), 96'(18));
        step(0, 0, 0, 0, 1, 4'd2);
        check("t6_ir_frz", 96'(instr_retired), 96'(3));
        check("t6_br_frz", 96'(bytes_retired), 96'(18));
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit r, iv, il, c;
            logic [3:0] cl;
            r  = ($urandom_range(0, 299) == 0) ||
                 ((m_err || (m_eos && q.size() == 0)) && $urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 3) != 0);
            il = ($urandom_range(0, 49) == 0);
            c  = 0;
            cl = 4'(m_avail());
            if (m_win_valid()) begin
                c  = $urandom_range(0, 1) == 1;
                cl = 4'($urandom_range(1, m_avail()));
                if ($urandom_range(0, 59) == 0) cl = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) == 0) begin
                c  = 1;
                cl = 4'($urandom_range(0, 15));
            end
            step(r, iv, 8'($urandom), il, c, cl);
        end
        compare_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
